stack_alu_seq: RTL and testbench
================================

Name: stack_alu_seq

Overview:
Multi-cycle arithmetic responder for the stack processor. The control unit issues a request with the two operands popped from the stack, and this block answers with a result, flags and a one-cycle done pulse. The control unit then pushes the result onto the stack.
ADD/SUB complete in a short fixed latency. MUL (shift-add) and DIV (restoring) iterate one bit per clock on operand magnitudes, then apply a sign fix-up.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement); iteration count for MUL/DIV

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request strobe, sampled only in IDLE
op  in  2  00=ADD, 01=SUB, 10=MUL, 11=DIV
in1  in  WIDTH  first operand (top of stack): augend, minuend, multiplicand, dividend
in2  in  WIDTH  second operand: addend, subtrahend, multiplier, divisor
result  out  WIDTH  registered result, held until the next accepted start
carryOut  out  1  ADD: unsigned carry out of MSB; SUB: 1 when in1>=in2 unsigned; 0 for MUL/DIV
ovf  out  1  signed overflow of the operation
dz  out  1  DIV with in2==0
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when result and flags are valid

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; result, carryOut, ovf, dz, busy, done all 0; iteration counter 0.
- States: IDLE, EXEC, ITER, FIX, DONE.
- IDLE: when start=1 at edge N, latch op, in1, in2 and set busy=1.
  - ADD, SUB, or DIV with in2==0 -> EXEC.
  - MUL, or DIV with in2!=0 -> ITER, loading |in1|, |in2|, the result sign, and counter=0.
- EXEC: at edge N+1, write result and flags, then go to DONE. done=1 in the cycle after edge N+1.
- ITER: one bit per edge; counter increments each edge; after WIDTH edges (counter==WIDTH-1) go to FIX.
- FIX: apply sign, write result and flags, go to DONE.
- MUL/DIV latency: done=1 in the cycle after edge N+WIDTH+1.
- DONE: done=1 for exactly one cycle, busy drops to 0, next state IDLE. A start seen in DONE is ignored.
- start while busy: ignored. Latched operands do not change; no queuing.
- Input changes after the accepting edge have no effect.
- ADD/SUB:
  - result = low WIDTH bits of in1+in2 or in1-in2.
  - ovf = signed overflow.
  - carryOut per the port definition.
- MUL:
  - result = low WIDTH bits of the signed 2*WIDTH-bit product.
  - ovf=1 if the product is outside the signed WIDTH range. Example: -128*-1 gives result 0x80, ovf=1.
- DIV:
  - Quotient truncates toward zero. Result sign = sign(in1) XOR sign(in2).
  - Remainder takes the sign of in1.
  - -128/-1 gives result 0x80, ovf=1.
- DIV by zero: result=0, dz=1, ovf=0, carryOut=0, 2-edge latency.
- Flags from the previous operation hold until the new result is written.
- Reset mid-operation returns to IDLE immediately with no done pulse; the in-flight request is lost.

Optional Feature:
- STACK_ALU_REM_EN defined: adds output rem (WIDTH bits), written together with result.
  - DIV: signed remainder.
  - DIV by zero: rem=in1.
  - ADD/SUB/MUL: rem=0.
  - Reset value 0.
- Undefined: no rem port and no remainder register. The remainder is discarded after FIX.

Test Plan:
1. ADD in1=2, in2=7 -> done after 2 edges; result=9, carryOut=0, ovf=0. Then ADD in1=17, in2=-18 -> result=-1 (0xFF).
2. SUB in1=8, in2=2 -> result=6, carryOut=1. SUB in1=4, in2=6 -> result=-2 (0xFE), carryOut=0, ovf=0.
3. MUL in1=3, in2=9 -> done after WIDTH+2=10 edges; result=27 (0x1B). MUL in1=18, in2=-1 -> result=-18 (0xEE). MUL -128*-1 -> 0x80, ovf=1.
4. DIV in1=54, in2=27 -> result=2 after 10 edges. DIV in1=2, in2=-2 -> result=-1. DIV in1=-7, in2=2 -> result=-3; with STACK_ALU_REM_EN, rem=-1.
5. DIV in1=5, in2=0 -> done after 2 edges; dz=1, result=0. Then ADD 1+1 -> dz cleared, result=2.
6. Start MUL 3*9, pulse start with DIV operands at edge N+3 -> ignored, result still 27. Separately, assert reset at edge N+4 of a MUL -> all outputs 0, no done pulse, next start accepted normally.

Source files
------------

// File: rtl/stack_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : stack_alu_seq
// Brief    : Multi-cycle arithmetic responder for the stack processor.
//            ADD/SUB (and DIV by zero) finish two edges after the accepting
//            edge. MUL (shift-add) and DIV (restoring) iterate one bit per
//            clock on operand magnitudes and then apply a sign fix-up.
// Options  : define STACK_ALU_REM_EN to add the signed remainder output rem.
// Revision : 1.0 - initial release
// ============================================================================
module stack_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             ovf,
  output logic             dz,
  output logic             busy,
  output logic             done
`ifdef STACK_ALU_REM_EN
  ,
  output logic [WIDTH-1:0] rem
`endif
);

  localparam logic [1:0] c_op_add = 2'b00;
  localparam logic [1:0] c_op_sub = 2'b01;
  localparam logic [1:0] c_op_mul = 2'b10;
  localparam logic [1:0] c_op_div = 2'b11;

  // Counter only has to reach WIDTH-1; keep at least one bit.
  localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched request
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg_res;
  logic [c_cnt_w-1:0] r_cnt;

  // Shift-add multiplier state (unsigned magnitudes)
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  // Restoring divider state (unsigned magnitudes)
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_prem;
  logic [WIDTH-1:0]   r_dvsr;

  // Architectural outputs
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_ovf;
  logic               r_dz;

`ifdef STACK_ALU_REM_EN
  logic               r_neg_a;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   w_rem_s;
`endif

  logic               w_iterate;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_sub;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic [WIDTH:0]     w_prem_sh;
  logic               w_prem_fits;
  logic [WIDTH-1:0]   w_prem_try;
  logic [2*WIDTH-1:0] w_prod_s;
  logic               w_mul_ovf;
  logic [WIDTH-1:0]   w_quo_s;
  logic               w_div_ovf;

  // Magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned.
  assign w_mag1    = in1[WIDTH-1] ? -in1 : in1;
  assign w_mag2    = in2[WIDTH-1] ? -in2 : in2;
  assign w_iterate = (op == c_op_mul) || ((op == c_op_div) && (in2 != '0));

  // Single-cycle ADD/SUB; the SUB borrow bit is the inverse of in1>=in2.
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub     = {1'b0, r_a} - {1'b0, r_b};
  assign w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
  assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);

  // Restoring divide step: partial remainder always stays below the divisor,
  // so WIDTH bits hold it and the trial difference never needs a sign bit.
  assign w_prem_sh   = {r_prem, r_quo[WIDTH-1]};
  assign w_prem_fits = (w_prem_sh >= {1'b0, r_dvsr});
  assign w_prem_try  = w_prem_sh[WIDTH-1:0] - r_dvsr;

  // Sign fix-up. A product fits when its top WIDTH+1 bits are all equal;
  // a quotient only overflows when positive with magnitude 2^(WIDTH-1).
  assign w_prod_s  = r_neg_res ? -r_acc : r_acc;
  assign w_mul_ovf = !((&w_prod_s[2*WIDTH-1:WIDTH-1]) || !(|w_prod_s[2*WIDTH-1:WIDTH-1]));
  assign w_quo_s   = r_neg_res ? -r_quo : r_quo;
  assign w_div_ovf = !r_neg_res && r_quo[WIDTH-1];

`ifdef STACK_ALU_REM_EN
  assign w_rem_s   = r_neg_a ? -r_prem : r_prem;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_iterate ? S_ITER : S_EXEC;
        end
      end
      S_EXEC: begin
        busy         = 1'b1;
        w_next_state = S_DONE;
      end
      S_ITER: begin
        busy = 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX: begin
        busy         = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request latch and per-bit MUL/DIV iteration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_neg_res <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_quo     <= '0;
      r_prem    <= '0;
      r_dvsr    <= '0;
`ifdef STACK_ALU_REM_EN
      r_neg_a   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_a       <= in1;
            r_b       <= in2;
            r_neg_res <= in1[WIDTH-1] ^ in2[WIDTH-1];
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier  <= w_mag2;
            r_quo     <= w_mag1;
            r_prem    <= '0;
            r_dvsr    <= w_mag2;
`ifdef STACK_ALU_REM_EN
            r_neg_a   <= in1[WIDTH-1];
`endif
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == c_op_mul) begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          end else begin
            r_prem <= w_prem_fits ? w_prem_try : w_prem_sh[WIDTH-1:0];
            r_quo  <= {r_quo[WIDTH-2:0], w_prem_fits};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result and flag register, written once per operation in EXEC or FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
`ifdef STACK_ALU_REM_EN
      r_rem    <= '0;
`endif
    end else if (r_state == S_EXEC) begin
      case (r_op)
        c_op_add: begin
          r_result <= w_sum[WIDTH-1:0];
          r_carry  <= w_sum[WIDTH];
          r_ovf    <= w_add_ovf;
          r_dz     <= 1'b0;
`ifdef STACK_ALU_REM_EN
          r_rem    <= '0;
`endif
        end
        c_op_sub: begin
          r_result <= w_sub[WIDTH-1:0];
          r_carry  <= ~w_sub[WIDTH];
          r_ovf    <= w_sub_ovf;
          r_dz     <= 1'b0;
`ifdef STACK_ALU_REM_EN
          r_rem    <= '0;
`endif
        end
        default: begin
          // Only a divide by zero reaches EXEC with a non-ADD/SUB opcode.
          r_result <= '0;
          r_carry  <= 1'b0;
          r_ovf    <= 1'b0;
          r_dz     <= 1'b1;
`ifdef STACK_ALU_REM_EN
          r_rem    <= r_a;
`endif
        end
      endcase
    end else if (r_state == S_FIX) begin
      r_carry <= 1'b0;
      r_dz    <= 1'b0;
      if (r_op == c_op_mul) begin
        r_result <= w_prod_s[WIDTH-1:0];
        r_ovf    <= w_mul_ovf;
`ifdef STACK_ALU_REM_EN
        r_rem    <= '0;
`endif
      end else begin
        r_result <= w_quo_s;
        r_ovf    <= w_div_ovf;
`ifdef STACK_ALU_REM_EN
        r_rem    <= w_rem_s;
`endif
      end
    end
  end

  assign result   = r_result;
  assign carryOut = r_carry;
  assign ovf      = r_ovf;
  assign dz       = r_dz;
`ifdef STACK_ALU_REM_EN
  assign rem      = r_rem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_alu_seq
// Brief    : Self-checking bench for stack_alu_seq: directed vector table,
//            hand-written busy/reset sequences, and random operations checked
//            against an integer-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_alu_seq;

  localparam int W       = 8;
  localparam int MAXWAIT = 64;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = '0;
  logic [W-1:0] in1   = '0;
  logic [W-1:0] in2   = '0;
  logic [W-1:0] result;
  logic         carryOut, ovf, dz, busy, done;
`ifdef STACK_ALU_REM_EN
  logic [W-1:0] rem;
`endif

  int total = 0;
  int bad   = 0;

  // Expected architectural state left by the previous completed operation
  logic [W-1:0] prev_res = '0;
  logic         prev_c = 1'b0, prev_v = 1'b0, prev_z = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic [W-1:0] rm;
    int           lat;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  vec_t tbl[$];

  stack_alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .result   (result),
    .carryOut (carryOut),
    .ovf      (ovf),
    .dz       (dz),
    .busy     (busy),
    .done     (done)
`ifdef STACK_ALU_REM_EN
    ,
    .rem      (rem)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit fits(input int x);
    return (x >= -(2 ** (W - 1))) && (x <= (2 ** (W - 1)) - 1);
  endfunction

  // Reference model: plain signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sb, ua, ub, t;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.rm = '0; e.lat = 2;
    case (o)
      OP_ADD: begin
        t = ua + ub;
        e.res = W'(t);
        e.c = (t >= 2 ** W);
        e.v = !fits(sa + sb);
      end
      OP_SUB: begin
        e.res = W'(ua - ub);
        e.c = (ua >= ub);
        e.v = !fits(sa - sb);
      end
      OP_MUL: begin
        t = sa * sb;
        e.res = W'(t);
        e.v = !fits(t);
        e.lat = W + 2;
      end
      default: begin
        if (sb == 0) begin
          e.z  = 1'b1;
          e.rm = a;
        end else begin
          t = sa / sb;
          e.res = W'(t);
          e.v = !fits(t);
          e.rm = W'(sa % sb);
          e.lat = W + 2;
        end
      end
    endcase
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] res, input logic c, input logic v,
                              input logic z, input logic [W-1:0] rm, input int lat);
    exp_t e;
    e.res = res; e.c = c; e.v = v; e.z = z; e.rm = rm; e.lat = lat;
    return e;
  endfunction

  task automatic add_vec(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.e = e;
    tbl.push_back(v);
  endtask

  // Issue one request, scramble inputs after acceptance, wait for done and
  // check latency, outputs, flag hold before write and the one-cycle pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
    int edges;
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op  = 2'($urandom);
    in1 = W'($urandom);
    in2 = W'($urandom);
    edges = 1;
    chk({tag, " busy_after_accept"}, busy, 1);
    chk({tag, " held_prev"}, {result, carryOut, ovf, dz}, {prev_res, prev_c, prev_v, prev_z});
    while (!done && edges < MAXWAIT) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, " done_seen"}, done, 1);
    chk({tag, " latency"}, edges, e.lat);
    chk({tag, " result"}, result, e.res);
    chk({tag, " carryOut"}, carryOut, e.c);
    chk({tag, " ovf"}, ovf, e.v);
    chk({tag, " dz"}, dz, e.z);
    chk({tag, " busy_at_done"}, busy, 0);
`ifdef STACK_ALU_REM_EN
    chk({tag, " rem"}, rem, e.rm);
`endif
    prev_res = e.res; prev_c = e.c; prev_v = e.v; prev_z = e.z;
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_len"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  edges;
    bit  seen;
    exp_t e;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    logic [W-1:0] corner [5];

    // Directed vectors: op, in1, in2 -> result, carry, ovf, dz, rem, latency
    add_vec(OP_ADD, 8'h02, 8'h07, mk(8'h09, 0, 0, 0, 8'h00, 2));
    add_vec(OP_ADD, 8'h11, 8'hEE, mk(8'hFF, 0, 0, 0, 8'h00, 2));
    add_vec(OP_ADD, 8'h7F, 8'h01, mk(8'h80, 0, 1, 0, 8'h00, 2));
    add_vec(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 0, 0, 8'h00, 2));
    add_vec(OP_ADD, 8'h80, 8'h80, mk(8'h00, 1, 1, 0, 8'h00, 2));
    add_vec(OP_SUB, 8'h08, 8'h02, mk(8'h06, 1, 0, 0, 8'h00, 2));
    add_vec(OP_SUB, 8'h04, 8'h06, mk(8'hFE, 0, 0, 0, 8'h00, 2));
    add_vec(OP_SUB, 8'h80, 8'h01, mk(8'h7F, 1, 1, 0, 8'h00, 2));
    add_vec(OP_SUB, 8'h00, 8'h00, mk(8'h00, 1, 0, 0, 8'h00, 2));
    add_vec(OP_MUL, 8'h03, 8'h09, mk(8'h1B, 0, 0, 0, 8'h00, 10));
    add_vec(OP_MUL, 8'h12, 8'hFF, mk(8'hEE, 0, 0, 0, 8'h00, 10));
    add_vec(OP_MUL, 8'h80, 8'hFF, mk(8'h80, 0, 1, 0, 8'h00, 10));
    add_vec(OP_MUL, 8'h7F, 8'h7F, mk(8'h01, 0, 1, 0, 8'h00, 10));
    add_vec(OP_MUL, 8'hF0, 8'h08, mk(8'h80, 0, 0, 0, 8'h00, 10));
    add_vec(OP_DIV, 8'h36, 8'h1B, mk(8'h02, 0, 0, 0, 8'h00, 10));
    add_vec(OP_DIV, 8'h02, 8'hFE, mk(8'hFF, 0, 0, 0, 8'h00, 10));
    add_vec(OP_DIV, 8'hF9, 8'h02, mk(8'hFD, 0, 0, 0, 8'hFF, 10));
    add_vec(OP_DIV, 8'h07, 8'hFE, mk(8'hFD, 0, 0, 0, 8'h01, 10));
    add_vec(OP_DIV, 8'h80, 8'hFF, mk(8'h80, 0, 1, 0, 8'h00, 10));
    add_vec(OP_DIV, 8'h80, 8'h01, mk(8'h80, 0, 0, 0, 8'h00, 10));
    add_vec(OP_DIV, 8'h03, 8'h07, mk(8'h00, 0, 0, 0, 8'h03, 10));
    add_vec(OP_DIV, 8'h05, 8'h00, mk(8'h00, 0, 0, 1, 8'h05, 2));
    add_vec(OP_ADD, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 8'h00, 2));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset result", result, 0);
    chk("reset flags", {carryOut, ovf, dz}, 0);
    chk("reset busy_done", {busy, done}, 0);
`ifdef STACK_ALU_REM_EN
    chk("reset rem", rem, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
    end

    // A start while busy is ignored; so is a start seen in DONE.
    @(negedge clk);
    start = 1'b1; op = OP_MUL; in1 = 8'd3; in2 = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    @(posedge clk);
    @(posedge clk);
    edges = 3;
    @(negedge clk);
    start = 1'b1; op = OP_DIV; in1 = 8'd100; in2 = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 4;
    while (!done && edges < MAXWAIT) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("busy_ignore done_seen", done, 1);
    chk("busy_ignore latency", edges, W + 2);
    chk("busy_ignore result", result, 8'h1B);
    chk("busy_ignore flags", {carryOut, ovf, dz}, 0);
    start = 1'b1; op = OP_ADD; in1 = 8'd1; in2 = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_ignore busy", busy, 0);
    chk("done_ignore result", result, 8'h1B);
    @(posedge clk);
    #1;
    chk("done_ignore idle", {busy, done}, 0);
    prev_res = 8'h1B; prev_c = 0; prev_v = 0; prev_z = 0;

    // Reset in the middle of a MUL: outputs clear, no done pulse.
    @(negedge clk);
    start = 1'b1; op = OP_MUL; in1 = 8'd5; in2 = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst result", result, 0);
    chk("midrst flags", {carryOut, ovf, dz}, 0);
    chk("midrst busy_done", {busy, done}, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst no_done", seen, 0);
    chk("midrst result_after", result, 0);
    prev_res = '0; prev_c = 0; prev_v = 0; prev_z = 0;
    run_op("post_rst", OP_ADD, 8'd2, 8'd7, mk(8'h09, 0, 0, 0, 8'h00, 2));

    // Random operations against the model, biased toward corner operands.
    corner[0] = 8'h80; corner[1] = 8'h7F; corner[2] = 8'hFF;
    corner[3] = 8'h00; corner[4] = 8'h01;
    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      e = model(ro, ra, rb);
      run_op($sformatf("rnd%0d op%0d %0h,%0h", i, ro, ra, rb), ro, ra, rb, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
